clock_set_ctrl: RTL
===================

Name: clock_set_ctrl

Overview:
- Time-setting controller for the sec/min/hour counter chain of the FPGA clock.
- Sequences user button events through an edit FSM and holds an editable copy of the time.
- Drives the chain's enable, load, setting1/2/3 and data_sec/min/hour inputs, and commits the edited time in a single-cycle load.
- Sits between the button conditioning logic and the counter chain top.

Parameters:
- SEC_MAX, 59, last valid seconds value.
- MIN_MAX, 59, last valid minutes value.
- HOUR_MAX, 23, last valid hours value.
- TIMEOUT_TICKS, 30, number of tick strobes with no button press in an edit state before the edit is aborted.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- tick  in  1  one-cycle strobe per counting period; used for blink and timeout only.
- btn_mode  in  1  one-cycle pulse, debounced: advance edit state.
- btn_up  in  1  one-cycle pulse, debounced: increment the field being edited.
- btn_down  in  1  one-cycle pulse, debounced: decrement the field being edited.
- cur_sec / cur_min / cur_hour  in  6 each  live counter-chain outputs.
- enable  out  1  counter-chain run enable.
- load  out  1  counter-chain load mode.
- setting1 / setting2 / setting3  out  1 each  sec/min/hour load strobes.
- data_sec / data_min / data_hour  out  6 each  values to be loaded.
- edit_field  out  2  0=none, 1=hour, 2=min, 3=sec.
- blink  out  1  display blink for the field being edited.

Behaviour:
- Reset: the synchronous, active-high reset dominates all other inputs. It forces:
  - state=RUN;
  - edit registers, data_* = 0;
  - enable=1, load=0, setting*=0;
  - edit_field=0, blink=0, timeout counter=0.
- States: RUN, SET_HOUR, SET_MIN, SET_SEC, COMMIT.
- RUN:
  - enable=1, load=0, edit_field=0, blink=0.
  - btn_mode: capture cur_hour/min/sec into the edit registers in the same cycle, then go to SET_HOUR.
  - btn_up and btn_down are ignored.
- SET_HOUR / SET_MIN / SET_SEC:
  - enable=0 (time is frozen); edit_field=1/2/3.
  - btn_up increments the selected field; MAX wraps to 0.
  - btn_down decrements the selected field; 0 wraps to MAX.
  - btn_up and btn_down in the same cycle: no change, but the timeout is still reset.
  - btn_mode advances the state: HOUR→MIN→SEC→COMMIT.
  - btn_mode together with up/down in the same cycle: mode wins and the up/down is discarded.
- blink: toggles on every tick while in an edit state. It is forced to 0 on entering RUN and restarts at 1 on entering SET_HOUR.
- Timeout:
  - The counter clears on any button pulse and on each state entry.
  - It increments on each tick.
  - When it reaches TIMEOUT_TICKS, the FSM returns to RUN with no load issued, and the edit is discarded.
- COMMIT (exactly 1 cycle):
  - load=1, setting1=setting2=setting3=1.
  - data_* = edit registers; enable=0.
  - Next cycle: RUN, load=0, setting*=0.
  - Buttons arriving during COMMIT are ignored.
- data_*:
  - Continuously reflect the edit registers.
  - They are only meaningful when load=1.
- Width rule: all fields are 6 bits. An edit register captured out of range (greater than its MAX) is clamped to 0 on the first up/down press.
- Reset mid-edit: the FSM returns to RUN immediately, with no load pulse.
- tick arriving in the same cycle as a button press: the button clears the timeout and the tick does not count.

Test Plan:
- Reset → enable=1, load=0, setting*=0, edit_field=0, data_*=0 on the cycle after reset is sampled high.
- cur=12:34:56, then mode, up×3 (hour), mode, down×35 (min), mode, up×4 (sec), mode → exactly one cycle with load=1, setting1/2/3=1, data_hour=15, data_min=59, data_sec=0; enable=0 throughout the edit.
- Wrap-around:
  - hour=23 plus up → 0;
  - min=0 plus down → 59;
  - sec=59 plus up → 0.
- Simultaneous events:
  - up+down in the same cycle → field unchanged;
  - mode+up in the same cycle in SET_MIN → state becomes SET_SEC and min is unchanged.
- Timeout: enter SET_MIN, then 30 ticks with no buttons → RUN, load never asserted, enable=1; with 29 ticks and then a press → stays in edit.
- Reset asserted in SET_SEC → RUN next cycle, no load/setting pulse, blink=0.

Source files
------------

// File: rtl/clock_set_ctrl_if.sv
// clock_set_ctrl_if: signal bundle between the time-setting controller and its neighbours.
//   master modport: the button/counter-chain side that drives tick, buttons and live time,
//                   and receives the chain controls.
//   slave modport : the controller itself.
// Signals:
//   tick, btn_mode, btn_up, btn_down    one-cycle strobes into the controller
//   cur_sec/min/hour [5:0]              live counter-chain time
//   enable, load, setting1/2/3          counter-chain controls
//   data_sec/min/hour [5:0]             values to load into the chain
//   edit_field [1:0]                    0=none, 1=hour, 2=min, 3=sec
//   blink                               display blink for the edited field
interface clock_set_ctrl_if;
  logic       tick;
  logic       btn_mode;
  logic       btn_up;
  logic       btn_down;
  logic [5:0] cur_sec;
  logic [5:0] cur_min;
  logic [5:0] cur_hour;
  logic       enable;
  logic       load;
  logic       setting1;
  logic       setting2;
  logic       setting3;
  logic [5:0] data_sec;
  logic [5:0] data_min;
  logic [5:0] data_hour;
  logic [1:0] edit_field;
  logic       blink;

  modport master (
    output tick, btn_mode, btn_up, btn_down, cur_sec, cur_min, cur_hour,
    input  enable, load, setting1, setting2, setting3,
    input  data_sec, data_min, data_hour, edit_field, blink
  );

  modport slave (
    input  tick, btn_mode, btn_up, btn_down, cur_sec, cur_min, cur_hour,
    output enable, load, setting1, setting2, setting3,
    output data_sec, data_min, data_hour, edit_field, blink
  );
endinterface

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: edit FSM for setting the sec/min/hour counter chain.
//   i_clock  : system clock, rising edge.
//   i_reset  : synchronous active-high reset, dominates everything.
//   bus      : clock_set_ctrl_if.slave -- buttons, tick and live time in; chain
//              enable/load/setting strobes, load data, edit_field and blink out.
// A mode press in RUN snapshots the live time, then hour/min/sec are edited in turn and
// committed with a single-cycle load. Inactivity for TIMEOUT_TICKS ticks abandons the edit.
module clock_set_ctrl #(
  parameter int unsigned SEC_MAX       = 59,
  parameter int unsigned MIN_MAX       = 59,
  parameter int unsigned HOUR_MAX      = 23,
  parameter int unsigned TIMEOUT_TICKS = 30
) (
  input logic             i_clock,
  input logic             i_reset,
  clock_set_ctrl_if.slave bus
);

  localparam int unsigned TW = $clog2(TIMEOUT_TICKS + 1);

  localparam logic [2:0] ST_RUN      = 3'd0;
  localparam logic [2:0] ST_SET_HOUR = 3'd1;
  localparam logic [2:0] ST_SET_MIN  = 3'd2;
  localparam logic [2:0] ST_SET_SEC  = 3'd3;
  localparam logic [2:0] ST_COMMIT   = 3'd4;

  logic [2:0]    r_state;
  logic [5:0]    r_hour;
  logic [5:0]    r_min;
  logic [5:0]    r_sec;
  logic [TW-1:0] r_timeout;
  logic          r_blink;

  logic [2:0]    w_state_next;
  logic          w_edit;
  logic          w_any_btn;
  logic          w_timeout_hit;
  logic [5:0]    w_field;
  logic [5:0]    w_field_max;
  logic [5:0]    w_field_next;

  always_comb begin
    w_edit        = (r_state == ST_SET_HOUR) || (r_state == ST_SET_MIN) ||
                    (r_state == ST_SET_SEC);
    w_any_btn     = bus.btn_mode | bus.btn_up | bus.btn_down;
    // A tick alongside a button does not count; this tick would make the count reach the limit.
    w_timeout_hit = w_edit && !w_any_btn && bus.tick &&
                    (r_timeout == TW'(TIMEOUT_TICKS - 1));

    w_field     = 6'd0;
    w_field_max = 6'd0;
    case (r_state)
      ST_SET_HOUR: begin w_field = r_hour; w_field_max = 6'(HOUR_MAX); end
      ST_SET_MIN:  begin w_field = r_min;  w_field_max = 6'(MIN_MAX);  end
      ST_SET_SEC:  begin w_field = r_sec;  w_field_max = 6'(SEC_MAX);  end
      default:     begin w_field = 6'd0;   w_field_max = 6'd0;         end
    endcase

    // Out-of-range captures (> MAX) snap to 0 on the first up or down press.
    w_field_next = w_field;
    if (bus.btn_up && !bus.btn_down) begin
      w_field_next = (w_field >= w_field_max) ? 6'd0 : w_field + 6'd1;
    end else if (bus.btn_down && !bus.btn_up) begin
      if (w_field > w_field_max) begin
        w_field_next = 6'd0;
      end else if (w_field == 6'd0) begin
        w_field_next = w_field_max;
      end else begin
        w_field_next = w_field - 6'd1;
      end
    end

    w_state_next = r_state;
    case (r_state)
      ST_RUN:      if (bus.btn_mode) w_state_next = ST_SET_HOUR;
      ST_SET_HOUR: if (bus.btn_mode) w_state_next = ST_SET_MIN;
                   else if (w_timeout_hit) w_state_next = ST_RUN;
      ST_SET_MIN:  if (bus.btn_mode) w_state_next = ST_SET_SEC;
                   else if (w_timeout_hit) w_state_next = ST_RUN;
      ST_SET_SEC:  if (bus.btn_mode) w_state_next = ST_COMMIT;
                   else if (w_timeout_hit) w_state_next = ST_RUN;
      ST_COMMIT:   w_state_next = ST_RUN;
      default:     w_state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state   <= ST_RUN;
      r_hour    <= 6'd0;
      r_min     <= 6'd0;
      r_sec     <= 6'd0;
      r_timeout <= '0;
      r_blink   <= 1'b0;
    end else begin
      r_state <= w_state_next;

      if ((r_state == ST_RUN) && bus.btn_mode) begin
        r_hour <= bus.cur_hour;
        r_min  <= bus.cur_min;
        r_sec  <= bus.cur_sec;
      end else if (w_edit && !bus.btn_mode) begin
        case (r_state)
          ST_SET_HOUR: r_hour <= w_field_next;
          ST_SET_MIN:  r_min  <= w_field_next;
          ST_SET_SEC:  r_sec  <= w_field_next;
          default:     r_sec  <= r_sec;
        endcase
      end

      if (!w_edit || w_any_btn || (w_state_next != r_state)) begin
        r_timeout <= '0;
      end else if (bus.tick) begin
        r_timeout <= r_timeout + TW'(1);
      end

      if (w_state_next == ST_RUN) begin
        r_blink <= 1'b0;
      end else if (r_state == ST_RUN) begin
        r_blink <= 1'b1;
      end else if (w_edit && bus.tick) begin
        r_blink <= ~r_blink;
      end
    end
  end

  always_comb begin
    bus.enable    = (r_state == ST_RUN);
    bus.load      = (r_state == ST_COMMIT);
    bus.setting1  = (r_state == ST_COMMIT);
    bus.setting2  = (r_state == ST_COMMIT);
    bus.setting3  = (r_state == ST_COMMIT);
    bus.data_hour = r_hour;
    bus.data_min  = r_min;
    bus.data_sec  = r_sec;
    bus.blink     = r_blink;
    case (r_state)
      ST_SET_HOUR: bus.edit_field = 2'd1;
      ST_SET_MIN:  bus.edit_field = 2'd2;
      ST_SET_SEC:  bus.edit_field = 2'd3;
      default:     bus.edit_field = 2'd0;
    endcase
  end

endmodule
